// File: rtl/fetch_pc_nested_irq.sv
// Fetch-address stage: PC register plus next-PC select across undo, interrupt
// return/entry, branch prediction and sequential fetch, with a nested IRQ return stack.
module fetch_pc_nested_irq #(
    parameter int              XLEN       = 32,
    parameter int              NUM_IRQ    = 4,
    parameter int              NEST_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] VEC_BASE   = 32'h0000_0100,
    parameter int              VEC_STRIDE = 16,
    localparam int             LW         = $clog2(NUM_IRQ + 1),
    localparam int             DW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_predict,
    input  logic [XLEN-1:0]    branch_pc,
    input  logic               branch_undo,
    input  logic [XLEN-1:0]    pc_not_taken,
    input  logic               irq_ret,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus_4,
    output logic               flush,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               irq_active,
    output logic [LW-1:0]      irq_level,
    output logic [DW-1:0]      depth,
    output logic               underflow
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [LW-1:0]   level_q, level_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            underflow_q, underflow_d;
    logic [XLEN-1:0] stk_pc_q  [NEST_DEPTH];
    logic [XLEN-1:0] stk_pc_d  [NEST_DEPTH];
    logic [LW-1:0]   stk_lvl_q [NEST_DEPTH];
    logic [LW-1:0]   stk_lvl_d [NEST_DEPTH];

    logic [NUM_IRQ-1:0] elig;
    logic               have_w, pop, entry;
    logic [LW-1:0]      w_idx;
    logic [XLEN-1:0]    vec_pc, top_pc, seq_pc;
    logic [LW-1:0]      top_lvl;

    assign seq_pc = pc_q + XLEN'(4);
    assign elig   = irq_req & irq_en;

    // Lowest eligible index wins: scan downward so the last hit is the smallest.
    always_comb begin
        have_w = 1'b0;
        w_idx  = LW'(NUM_IRQ);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                have_w = 1'b1;
                w_idx  = LW'(i);
            end
        end
    end

    always_comb begin
        top_pc  = '0;
        top_lvl = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (DW'(i + 1) == depth_q) begin
                top_pc  = stk_pc_q[i];
                top_lvl = stk_lvl_q[i];
            end
        end
    end

    assign vec_pc = VEC_BASE + XLEN'(w_idx) * XLEN'(VEC_STRIDE);
    assign pop    = irq_ret && (depth_q != '0);
    assign entry  = have_w && (w_idx < level_q) && (depth_q < DW'(NEST_DEPTH))
                    && !stall && !branch_undo && !pop;

    always_comb begin
        pc_d        = pc_q;
        level_d     = level_q;
        depth_d     = depth_q;
        underflow_d = underflow_q || (irq_ret && (depth_q == '0));
        stk_pc_d    = stk_pc_q;
        stk_lvl_d   = stk_lvl_q;
        flush       = 1'b0;
        if (branch_undo) begin
            pc_d  = pc_not_taken;
            flush = 1'b1;
        end else if (pop) begin
            pc_d    = top_pc;
            level_d = top_lvl;
            depth_d = depth_q - DW'(1);
            flush   = 1'b1;
        end else if (entry) begin
            // Push the not-yet-decoded fetch address so it is refetched on return.
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (DW'(i) == depth_q) begin
                    stk_pc_d[i]  = pc_q;
                    stk_lvl_d[i] = level_q;
                end
            end
            pc_d    = vec_pc;
            level_d = w_idx;
            depth_d = depth_q + DW'(1);
            flush   = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (branch_predict) begin
            pc_d  = branch_pc;
            flush = 1'b1;
        end else begin
            pc_d = seq_pc;
        end
        if (rst) flush = 1'b0;
    end

    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            irq_ack[i] = entry && !rst && (w_idx == LW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            level_q     <= LW'(NUM_IRQ);
            depth_q     <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_pc_q[i]  <= '0;
                stk_lvl_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            level_q     <= level_d;
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
            stk_pc_q    <= stk_pc_d;
            stk_lvl_q   <= stk_lvl_d;
        end
    end

    assign mem_addr   = rst ? RESET_PC : pc_d;
    assign pc         = pc_q;
    assign pc_plus_4  = seq_pc;
    assign irq_active = (depth_q != '0);
    assign irq_level  = level_q;
    assign depth      = depth_q;
    assign underflow  = underflow_q;

endmodule
